// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Captures up to two retired instructions per cycle from a dual-issue commit
// stage and queues them as trace records for an external consumer using a
// valid/ready handshake. A cycle's commits are either all accepted or all
// dropped. Dropped commits still consume sequence numbers, bump a saturating
// drop counter, and flag the next accepted record as "lost".
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i               capture enable (0 = commits are ignored, not dropped)
//   commit_ack_i[1:0]      per-port commit valid, port 0 is the older one
//   commit_pc_i            {port1, port0} 64-bit PCs
//   commit_instr_i         {port1, port0} 32-bit instruction words
//   commit_rd_i            {port1, port0} 5-bit destination registers
//   commit_wdata_i         {port1, port0} 64-bit write-back data
//   commit_we_i[1:0]       per-port register write flag
//   priv_lvl_i[1:0]        privilege level shared by both ports
//   exception_valid_i      exception on port 0 this cycle
//   exception_cause_i      exception cause
//   trace_valid_o          head record valid
//   trace_ready_i          consumer accepts head record
//   trace_*_o              head record fields (zero while no record is held)
//   drop_cnt_o             saturating count of dropped records
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic [1:0]   commit_ack_i,
  input  logic [127:0] commit_pc_i,
  input  logic [63:0]  commit_instr_i,
  input  logic [9:0]   commit_rd_i,
  input  logic [127:0] commit_wdata_i,
  input  logic [1:0]   commit_we_i,
  input  logic [1:0]   priv_lvl_i,
  input  logic         exception_valid_i,
  input  logic [63:0]  exception_cause_i,
  output logic         trace_valid_o,
  input  logic         trace_ready_i,
  output logic [63:0]  trace_pc_o,
  output logic [31:0]  trace_instr_o,
  output logic [4:0]   trace_rd_o,
  output logic [63:0]  trace_wdata_o,
  output logic         trace_we_o,
  output logic [1:0]   trace_priv_o,
  output logic         trace_exc_o,
  output logic [63:0]  trace_cause_o,
  output logic [15:0]  trace_seq_o,
  output logic         trace_lost_o,
  output logic [31:0]  drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        we;
    logic [1:0]  priv;
    logic        exc;
    logic [63:0] cause;
    logic [15:0] seq;
    logic        lost;
  } rec_t;

  // Saturating add of this cycle's dropped-candidate count.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Storage (data only, never reset: validity is tracked by count_q).
  rec_t mem_q [DEPTH];

  // Control state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [15:0]   seq_q,    seq_d;
  logic          lost_q,   lost_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;

  // Per-cycle capture decode
  logic          cand0, cand1;
  logic [1:0]    n_cand;
  logic [AW:0]   free_slots;
  logic          push, drop, pop;
  logic          wr0_en, wr1_en;
  logic [AW-1:0] wr0_idx, wr1_idx;
  rec_t          rec_p0, rec_p1, rec0, rec1;
  rec_t          head;

  always_comb begin
    cand0 = enable_i & commit_ack_i[0];
    cand1 = enable_i & commit_ack_i[1];
    n_cand = {1'b0, cand0} + {1'b0, cand1};

    // Room is judged on start-of-cycle occupancy; a concurrent pop does not help.
    free_slots = DEPTH_W - count_q;
    push = (n_cand != 2'd0) && (free_slots >= (AW+1)'(n_cand));
    drop = (n_cand != 2'd0) && !push;
    pop  = (count_q != '0) && trace_ready_i;

    // Candidate records built straight from the commit ports.
    rec_p0.pc    = commit_pc_i[63:0];
    rec_p0.instr = commit_instr_i[31:0];
    rec_p0.rd    = commit_rd_i[4:0];
    rec_p0.wdata = commit_wdata_i[63:0];
    rec_p0.we    = commit_we_i[0];
    rec_p0.priv  = priv_lvl_i;
    rec_p0.exc   = exception_valid_i;
    rec_p0.cause = exception_valid_i ? exception_cause_i : 64'd0;
    rec_p0.seq   = seq_q;
    rec_p0.lost  = lost_q;

    rec_p1.pc    = commit_pc_i[127:64];
    rec_p1.instr = commit_instr_i[63:32];
    rec_p1.rd    = commit_rd_i[9:5];
    rec_p1.wdata = commit_wdata_i[127:64];
    rec_p1.we    = commit_we_i[1];
    rec_p1.priv  = priv_lvl_i;
    rec_p1.exc   = 1'b0;
    rec_p1.cause = 64'd0;
    rec_p1.seq   = seq_q;
    rec_p1.lost  = lost_q;

    // Slot 0 takes the oldest candidate; slot 1 is only used for a dual
    // commit, where port 1 follows port 0 and inherits neither lost nor seq.
    rec0 = cand0 ? rec_p0 : rec_p1;
    rec1 = rec_p1;
    rec1.seq  = seq_q + 16'd1;
    rec1.lost = 1'b0;

    wr0_en  = push;
    wr1_en  = push && cand0 && cand1;
    wr0_idx = wr_ptr_q;
    wr1_idx = wr_ptr_q + AW'(1);

    wr_ptr_d = push ? (wr_ptr_q + AW'(n_cand)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + (push ? (AW+1)'(n_cand) : '0) - (pop ? (AW+1)'(1) : '0);

    // Every candidate consumes a sequence number, written or dropped.
    seq_d = seq_q + 16'(n_cand);

    lost_d = lost_q;
    if (drop)      lost_d = 1'b1;
    else if (push) lost_d = 1'b0;

    drop_cnt_d = drop ? sat_add32(drop_cnt_q, n_cand) : drop_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      lost_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      lost_q     <= lost_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr0_en) mem_q[wr0_idx] <= rec0;
    if (wr1_en) mem_q[wr1_idx] <= rec1;
  end

  // Head read port. Fields are forced to zero while empty so that reset
  // (which empties the FIFO asynchronously) also clears every data output.
  always_comb begin
    head = mem_q[rd_ptr_q];
    trace_valid_o = (count_q != '0);
    if (!trace_valid_o) head = '0;
    trace_pc_o    = head.pc;
    trace_instr_o = head.instr;
    trace_rd_o    = head.rd;
    trace_wdata_o = head.wdata;
    trace_we_o    = head.we;
    trace_priv_o  = head.priv;
    trace_exc_o   = head.exc;
    trace_cause_o = head.cause;
    trace_seq_o   = head.seq;
    trace_lost_o  = head.lost;
    drop_cnt_o    = drop_cnt_q;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Randomized and directed stimulus against a queue-based reference model.
// The stimulus task decides, from the capture rules, which records a cycle
// produces and pushes them into exp_q; an independent monitor on the falling
// edge compares the DUT head against the oldest expected record and retires
// it when the consumer accepts.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        we;
    logic [1:0]  priv;
    logic        exc;
    logic [63:0] cause;
    logic [15:0] seq;
    logic        lost;
  } rec_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         enable_i;
  logic [1:0]   commit_ack_i;
  logic [127:0] commit_pc_i;
  logic [63:0]  commit_instr_i;
  logic [9:0]   commit_rd_i;
  logic [127:0] commit_wdata_i;
  logic [1:0]   commit_we_i;
  logic [1:0]   priv_lvl_i;
  logic         exception_valid_i;
  logic [63:0]  exception_cause_i;
  logic         trace_valid_o;
  logic         trace_ready_i;
  logic [63:0]  trace_pc_o;
  logic [31:0]  trace_instr_o;
  logic [4:0]   trace_rd_o;
  logic [63:0]  trace_wdata_o;
  logic         trace_we_o;
  logic [1:0]   trace_priv_o;
  logic         trace_exc_o;
  logic [63:0]  trace_cause_o;
  logic [15:0]  trace_seq_o;
  logic         trace_lost_o;
  logic [31:0]  drop_cnt_o;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .commit_ack_i(commit_ack_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_i(commit_rd_i),
    .commit_wdata_i(commit_wdata_i), .commit_we_i(commit_we_i),
    .priv_lvl_i(priv_lvl_i), .exception_valid_i(exception_valid_i),
    .exception_cause_i(exception_cause_i), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
    .trace_instr_o(trace_instr_o), .trace_rd_o(trace_rd_o),
    .trace_wdata_o(trace_wdata_o), .trace_we_o(trace_we_o),
    .trace_priv_o(trace_priv_o), .trace_exc_o(trace_exc_o),
    .trace_cause_o(trace_cause_o), .trace_seq_o(trace_seq_o),
    .trace_lost_o(trace_lost_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  rec_t        exp_q[$];
  int          pend = 0;            // records pushed into exp_q for the coming edge
  logic [15:0] m_seq = 16'd0;
  logic        m_lost = 1'b0;
  longint      exp_drop = 0;        // includes the coming edge
  longint      exp_drop_vis = 0;    // as visible on drop_cnt_o now

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic [63:0] wdata,
                              input logic we, input logic [1:0] priv, input logic exc,
                              input logic [63:0] cause, input logic [15:0] seq,
                              input logic lost);
    rec_t r;
    r.pc = pc; r.instr = instr; r.rd = rd; r.wdata = wdata; r.we = we;
    r.priv = priv; r.exc = exc; r.cause = cause; r.seq = seq; r.lost = lost;
    return r;
  endfunction

  // One clock cycle of stimulus; inputs change just after a rising edge.
  task automatic drive(input logic en, input logic [1:0] ack, input logic rdy,
                       input logic excv, input logic [63:0] cause,
                       input logic [63:0] pc0, input logic [63:0] pc1);
    int nc;
    enable_i          = en;
    commit_ack_i      = ack;
    trace_ready_i     = rdy;
    exception_valid_i = excv;
    exception_cause_i = cause;
    commit_pc_i       = {pc1, pc0};
    commit_instr_i    = {$urandom, $urandom};
    commit_rd_i       = 10'($urandom);
    commit_wdata_i    = {$urandom, $urandom, $urandom, $urandom};
    commit_we_i       = 2'($urandom);
    priv_lvl_i        = 2'($urandom);

    nc = en ? (int'(ack[0]) + int'(ack[1])) : 0;
    exp_drop_vis = exp_drop;
    pend = 0;
    if (nc > 0) begin
      if (DEPTH - exp_q.size() >= nc) begin
        if (ack[0])
          exp_q.push_back(mk(pc0, commit_instr_i[31:0], commit_rd_i[4:0],
                             commit_wdata_i[63:0], commit_we_i[0], priv_lvl_i,
                             excv, excv ? cause : 64'd0, m_seq, m_lost));
        if (ack[1])
          exp_q.push_back(mk(pc1, commit_instr_i[63:32], commit_rd_i[9:5],
                             commit_wdata_i[127:64], commit_we_i[1], priv_lvl_i,
                             1'b0, 64'd0, m_seq + (ack[0] ? 16'd1 : 16'd0),
                             ack[0] ? 1'b0 : m_lost));
        m_lost = 1'b0;
        pend = nc;
      end else begin
        exp_drop = exp_drop + nc;
        if (exp_drop > 64'hFFFF_FFFF) exp_drop = 64'hFFFF_FFFF;
        m_lost = 1'b1;
      end
      m_seq = m_seq + 16'(nc);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, rdy, 1'b0, 64'd0, 64'd0, 64'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    enable_i = 1'b0; commit_ack_i = 2'b00; trace_ready_i = 1'b0;
    exception_valid_i = 1'b0;
    pend = 0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", 256'(trace_valid_o), 256'd0);
    chk("rst_drop",  256'(drop_cnt_o),    256'd0);
    chk("rst_pc",    256'(trace_pc_o),    256'd0);
    exp_q.delete();
    m_seq = 16'd0; m_lost = 1'b0; exp_drop = 0; exp_drop_vis = 0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Monitor: compares the visible head against the model on every falling edge.
  always @(negedge clk_i) begin
    int occ;
    rec_t act;
    occ = exp_q.size() - pend;
    chk("valid", 256'(trace_valid_o), 256'(occ > 0));
    chk("drop_cnt", 256'(drop_cnt_o), 256'(exp_drop_vis));
    if (occ > 0) begin
      act = mk(trace_pc_o, trace_instr_o, trace_rd_o, trace_wdata_o, trace_we_o,
               trace_priv_o, trace_exc_o, trace_cause_o, trace_seq_o, trace_lost_o);
      chk("head", 256'(act), 256'(exp_q[0]));
      if (trace_ready_i) void'(exp_q.pop_front());
    end
  end

  initial begin
    rst_ni = 1'b0;
    enable_i = 1'b0; commit_ack_i = 2'b00; trace_ready_i = 1'b0;
    commit_pc_i = '0; commit_instr_i = '0; commit_rd_i = '0; commit_wdata_i = '0;
    commit_we_i = '0; priv_lvl_i = '0; exception_valid_i = 1'b0; exception_cause_i = '0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("reset_valid", 256'(trace_valid_o), 256'd0);
    chk("reset_seq",   256'(trace_seq_o),   256'd0);
    chk("reset_cause", 256'(trace_cause_o), 256'd0);
    chk("reset_drop",  256'(drop_cnt_o),    256'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Dual commit into an empty FIFO: port 0 first, seq 0 then 1.
    drive(1'b1, 2'b11, 1'b1, 1'b0, 64'd0, 64'h1000, 64'h1004);
    chk("dual_pc0",  256'(trace_pc_o),   256'h1000);
    chk("dual_seq0", 256'(trace_seq_o),  256'd0);
    chk("dual_lost", 256'(trace_lost_o), 256'd0);
    idle(1'b1, 4);

    // Fill to 7, drop a dual commit, then pop plus single commit.
    do_reset();
    for (int i = 0; i < 7; i++)
      drive(1'b1, 2'b01, 1'b0, 1'b0, 64'd0, 64'h2000 + 64'(4*i), 64'd0);
    drive(1'b1, 2'b11, 1'b0, 1'b0, 64'd0, 64'h3000, 64'h3004);
    chk("drop2", 256'(drop_cnt_o), 256'd2);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 64'd0, 64'h4000, 64'd0);
    idle(1'b1, 10);

    // Exception attaches to a port-0 record and not to the following one.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 64'h2, 64'h5000, 64'd0);
    chk("exc_flag",  256'(trace_exc_o),   256'd1);
    chk("exc_cause", 256'(trace_cause_o), 256'h2);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 64'h7, 64'h5004, 64'd0);
    idle(1'b1, 3);

    // Full FIFO with a pop and a single commit in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'b11, 1'b0, 1'b0, 64'd0, 64'($urandom), 64'($urandom));
    drive(1'b1, 2'b01, 1'b1, 1'b0, 64'd0, 64'h6000, 64'd0);
    chk("full_drop", 256'(drop_cnt_o), 256'd1);
    idle(1'b1, 10);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      drive(($urandom % 8) != 0, 2'($urandom), ($urandom % 10) < 6,
            ($urandom % 4) == 0, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
    idle(1'b1, 12);

    // Reset with five records buffered; first capture afterwards gets seq 0.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2'b01, 1'b0, 1'b0, 64'd0, 64'h7000 + 64'(4*i), 64'd0);
    do_reset();
    drive(1'b1, 2'b01, 1'b1, 1'b0, 64'd0, 64'h8000, 64'd0);
    chk("post_rst_seq", 256'(trace_seq_o), 256'd0);
    idle(1'b1, 2);

    // Drive the sequence counter to 0xFFFE and check the wrap.
    do_reset();
    while (m_seq != 16'hFFFE)
      drive(1'b1, 2'b11, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    idle(1'b1, 10);
    drive(1'b1, 2'b11, 1'b0, 1'b0, 64'd0, 64'h9000, 64'h9004);
    chk("wrap_seq0", 256'(trace_seq_o),  256'hFFFE);
    chk("wrap_lost", 256'(trace_lost_o), 256'd1);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 64'd0, 64'h9008, 64'd0);
    idle(1'b1, 6);

    chk("drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
